axi_outstanding_limiter: RTL

//  Caps in-flight AXI4 read and write transactions issued by a kernel m_axi master.

---
 rtl/axi_outstanding_limiter_pkg.sv | 16 +
 rtl/axi_credit_counter.sv | 43 ++++
 rtl/axi_outstanding_limiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_outstanding_limiter_pkg.sv
// Shared constants for the outstanding-transaction limiter and its credit counters.
package axi_outstanding_limiter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Smallest credit limit that still lets traffic through.
  localparam int MIN_LIMIT = 1;

endpackage

// File: rtl/axi_credit_counter.sv
// Up/down credit counter: count of in-flight items plus an "another one allowed" flag.
module axi_credit_counter
  import axi_outstanding_limiter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int LIMIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             avail
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  generate
    if (LIMIT < MIN_LIMIT || LIMIT > (2 ** WIDTH) - 1) begin : g_bad_limit
      $error("axi_credit_counter: LIMIT does not fit in WIDTH bits or is below 1");
    end
  endgenerate

  // A decrement at zero is a protocol violation upstream; the count clamps at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign avail = (count < LIMIT_W);

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(dec && !inc && count == '0));
    end
  end

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Caps in-flight AXI4 reads/writes of a kernel master and holds W data until its
// AW has been issued downstream. Payloads pass through combinationally.
module axi_outstanding_limiter #(
  parameter int C_M_AXI_ID_WIDTH    = 8,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int C_M_AXI_WSTRB_WIDTH = 64,
  parameter int MAX_RD_OUTSTANDING  = 16,
  parameter int MAX_WR_OUTSTANDING  = 16,
  parameter int CNT_WIDTH           = 5
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  // master-facing write address
  input  logic [C_M_AXI_ID_WIDTH-1:0]    in_AWID,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_AWADDR,
  input  logic [7:0]                     in_AWLEN,
  input  logic [2:0]                     in_AWSIZE,
  input  logic [1:0]                     in_AWBURST,
  input  logic [0:0]                     in_AWLOCK,
  input  logic [3:0]                     in_AWCACHE,
  input  logic [2:0]                     in_AWPROT,
  input  logic [3:0]                     in_AWQOS,
  input  logic [3:0]                     in_AWREGION,
  input  logic                           in_AWVALID,
  output logic                           in_AWREADY,
  // master-facing write data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  in_WDATA,
  input  logic [C_M_AXI_WSTRB_WIDTH-1:0] in_WSTRB,
  input  logic                           in_WLAST,
  input  logic                           in_WVALID,
  output logic                           in_WREADY,
  // master-facing write response
  output logic [C_M_AXI_ID_WIDTH-1:0]    in_BID,
  output logic [1:0]                     in_BRESP,
  output logic                           in_BVALID,
  input  logic                           in_BREADY,
  // master-facing read address
  input  logic [C_M_AXI_ID_WIDTH-1:0]    in_ARID,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_ARADDR,
  input  logic [7:0]                     in_ARLEN,
  input  logic [2:0]                     in_ARSIZE,
  input  logic [1:0]                     in_ARBURST,
  input  logic [0:0]                     in_ARLOCK,
  input  logic [3:0]                     in_ARCACHE,
  input  logic [2:0]                     in_ARPROT,
  input  logic [3:0]                     in_ARQOS,
  input  logic [3:0]                     in_ARREGION,
  input  logic                           in_ARVALID,
  output logic                           in_ARREADY,
  // master-facing read data
  output logic [C_M_AXI_ID_WIDTH-1:0]    in_RID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  in_RDATA,
  output logic [1:0]                     in_RRESP,
  output logic                           in_RLAST,
  output logic                           in_RVALID,
  input  logic                           in_RREADY,
  // interconnect-facing write address
  output logic [C_M_AXI_ID_WIDTH-1:0]    out_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_AWADDR,
  output logic [7:0]                     out_AWLEN,
  output logic [2:0]                     out_AWSIZE,
  output logic [1:0]                     out_AWBURST,
  output logic [0:0]                     out_AWLOCK,
  output logic [3:0]                     out_AWCACHE,
  output logic [2:0]                     out_AWPROT,
  output logic [3:0]                     out_AWQOS,
  output logic [3:0]                     out_AWREGION,
  output logic                           out_AWVALID,
  input  logic                           out_AWREADY,
  // interconnect-facing write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]  out_WDATA,
  output logic [C_M_AXI_WSTRB_WIDTH-1:0] out_WSTRB,
  output logic                           out_WLAST,
  output logic                           out_WVALID,
  input  logic                           out_WREADY,
  // interconnect-facing write response
  input  logic [C_M_AXI_ID_WIDTH-1:0]    out_BID,
  input  logic [1:0]                     out_BRESP,
  input  logic                           out_BVALID,
  output logic                           out_BREADY,
  // interconnect-facing read address
  output logic [C_M_AXI_ID_WIDTH-1:0]    out_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_ARADDR,
  output logic [7:0]                     out_ARLEN,
  output logic [2:0]                     out_ARSIZE,
  output logic [1:0]                     out_ARBURST,
  output logic [0:0]                     out_ARLOCK,
  output logic [3:0]                     out_ARCACHE,
  output logic [2:0]                     out_ARPROT,
  output logic [3:0]                     out_ARQOS,
  output logic [3:0]                     out_ARREGION,
  output logic                           out_ARVALID,
  input  logic                           out_ARREADY,
  // interconnect-facing read data
  input  logic [C_M_AXI_ID_WIDTH-1:0]    out_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  out_RDATA,
  input  logic [1:0]                     out_RRESP,
  input  logic                           out_RLAST,
  input  logic                           out_RVALID,
  output logic                           out_RREADY,
  // status
  output logic [CNT_WIDTH-1:0]           rd_outstanding,
  output logic [CNT_WIDTH-1:0]           wr_outstanding,
  output logic                           idle
);

  logic                 run;
  logic                 rd_ok;
  logic                 wr_ok;
  logic                 wp_avail;
  logic                 w_open;
  logic [CNT_WIDTH-1:0] aw_wpend;
  logic                 ar_fire;
  logic                 r_done;
  logic                 aw_fire;
  logic                 wl_fire;
  logic                 b_done;

  assign run = ~ap_rst;

  assign out_AWID     = in_AWID;
  assign out_AWADDR   = in_AWADDR;
  assign out_AWLEN    = in_AWLEN;
  assign out_AWSIZE   = in_AWSIZE;
  assign out_AWBURST  = in_AWBURST;
  assign out_AWLOCK   = in_AWLOCK;
  assign out_AWCACHE  = in_AWCACHE;
  assign out_AWPROT   = in_AWPROT;
  assign out_AWQOS    = in_AWQOS;
  assign out_AWREGION = in_AWREGION;

  assign out_WDATA    = in_WDATA;
  assign out_WSTRB    = in_WSTRB;
  assign out_WLAST    = in_WLAST;

  assign in_BID       = out_BID;
  assign in_BRESP     = out_BRESP;

  assign out_ARID     = in_ARID;
  assign out_ARADDR   = in_ARADDR;
  assign out_ARLEN    = in_ARLEN;
  assign out_ARSIZE   = in_ARSIZE;
  assign out_ARBURST  = in_ARBURST;
  assign out_ARLOCK   = in_ARLOCK;
  assign out_ARCACHE  = in_ARCACHE;
  assign out_ARPROT   = in_ARPROT;
  assign out_ARQOS    = in_ARQOS;
  assign out_ARREGION = in_ARREGION;

  assign in_RID       = out_RID;
  assign in_RDATA     = out_RDATA;
  assign in_RRESP     = out_RRESP;
  assign in_RLAST     = out_RLAST;

  // Gates use only registered credit state, so a presented VALID cannot drop
  // until its own handshake consumes the credit.
  assign out_ARVALID = run & in_ARVALID & rd_ok;
  assign in_ARREADY  = run & out_ARREADY & rd_ok;
  assign out_AWVALID = run & in_AWVALID & wr_ok;
  assign in_AWREADY  = run & out_AWREADY & wr_ok;

  assign w_open      = (aw_wpend != '0);
  assign out_WVALID  = run & in_WVALID & w_open;
  assign in_WREADY   = run & out_WREADY & w_open;

  assign in_RVALID   = run & out_RVALID;
  assign out_RREADY  = run & in_RREADY;
  assign in_BVALID   = run & out_BVALID;
  assign out_BREADY  = run & in_BREADY;

  assign ar_fire = out_ARVALID & out_ARREADY;
  assign r_done  = out_RVALID & out_RREADY & out_RLAST;
  assign aw_fire = out_AWVALID & out_AWREADY;
  assign wl_fire = out_WVALID & out_WREADY & out_WLAST;
  assign b_done  = out_BVALID & out_BREADY;

  axi_credit_counter #(.WIDTH(CNT_WIDTH), .LIMIT(MAX_RD_OUTSTANDING)) u_rd_credit (
    .clk   (ap_clk),
    .reset (ap_rst),
    .inc   (ar_fire),
    .dec   (r_done),
    .count (rd_outstanding),
    .avail (rd_ok)
  );

  axi_credit_counter #(.WIDTH(CNT_WIDTH), .LIMIT(MAX_WR_OUTSTANDING)) u_wr_credit (
    .clk   (ap_clk),
    .reset (ap_rst),
    .inc   (aw_fire),
    .dec   (b_done),
    .count (wr_outstanding),
    .avail (wr_ok)
  );

  axi_credit_counter #(.WIDTH(CNT_WIDTH), .LIMIT(MAX_WR_OUTSTANDING)) u_aw_wpend (
    .clk   (ap_clk),
    .reset (ap_rst),
    .inc   (aw_fire),
    .dec   (wl_fire),
    .count (aw_wpend),
    .avail (wp_avail)
  );

  assign idle = (rd_outstanding == '0) && (wr_outstanding == '0) && (aw_wpend == '0);

  // Pending-W count is bounded by write credits, so it can never be full on an AW.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst && aw_fire) begin
      assert (wp_avail);
    end
  end

endmodule
